// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer
//   Expands one command per valid/ready handshake into a multi-cycle strobe sequence
//   for an external WIDTH-bit up/down/shift counter. Supported commands are NOP,
//   CLEAR, INC_N, DEC_N, LOAD_MSB, LOAD_LSB, SEEK and ROTL_N.
//
// Ports
//   Clock, ResetN              rising-edge clock, asynchronous active-low reset
//   CmdValid / CmdReady        command handshake; CmdReady is high only in IDLE
//   CmdOp, CmdData             opcode and operand, latched on accept
//   CounterOut                 counter value, read back for SEEK and ROTL_N
//   DoReset .. DoShiftR2L      registered counter strobes, at most one high per cycle
//   CounterInMSB/LSB           counter serial-input bits
//   Busy                       high while the command runs
//   Done                       one-cycle completion pulse

module counter_cmd_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [2:0]       CmdOp,
  input  logic [WIDTH-1:0] CmdData,
  input  logic [WIDTH-1:0] CounterOut,
  output logic             DoReset,
  output logic             DoIncrement,
  output logic             DoDecrement,
  output logic             DoShiftL2R,
  output logic             DoShiftR2L,
  output logic             CounterInMSB,
  output logic             CounterInLSB,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  localparam logic [2:0] OpNop     = 3'b000;
  localparam logic [2:0] OpClear   = 3'b001;
  localparam logic [2:0] OpIncN    = 3'b010;
  localparam logic [2:0] OpDecN    = 3'b011;
  localparam logic [2:0] OpLoadMsb = 3'b100;
  localparam logic [2:0] OpLoadLsb = 3'b101;
  localparam logic [2:0] OpSeek    = 3'b110;
  localparam logic [2:0] OpRotlN   = 3'b111;

  // One-hot strobe vector positions.
  localparam logic [4:0] StbReset = 5'b10000;
  localparam logic [4:0] StbInc   = 5'b01000;
  localparam logic [4:0] StbDec   = 5'b00100;
  localparam logic [4:0] StbL2R   = 5'b00010;
  localparam logic [4:0] StbR2L   = 5'b00001;

  stateT            stateQ, stateD;
  logic [2:0]       opQ, opD;
  logic [WIDTH-1:0] countQ, countD;
  logic [WIDTH-1:0] dataQ, dataD;
  logic [4:0]       strobeQ, strobeD;
  logic             inLsbQ, inLsbD;
  logic             inMsbQ, inMsbD;

  logic             accept;
  logic [WIDTH-1:0] lenAcc;
  logic [4:0]       strobeAcc;

  assign accept = CmdValid && (stateQ == StIdle);

  // Sequence length and strobe for the command being offered this cycle.
  always_comb begin
    lenAcc    = '0;
    strobeAcc = '0;
    unique case (CmdOp)
      OpNop: begin
        lenAcc    = '0;
        strobeAcc = '0;
      end
      OpClear: begin
        lenAcc    = WIDTH'(1);
        strobeAcc = StbReset;
      end
      OpIncN: begin
        lenAcc    = CmdData;
        strobeAcc = StbInc;
      end
      OpDecN: begin
        lenAcc    = CmdData;
        strobeAcc = StbDec;
      end
      OpLoadMsb: begin
        lenAcc    = WIDTH'(WIDTH);
        strobeAcc = StbR2L;
      end
      OpLoadLsb: begin
        lenAcc    = WIDTH'(WIDTH);
        strobeAcc = StbL2R;
      end
      OpSeek: begin
        if (CmdData > CounterOut) begin
          lenAcc    = CmdData - CounterOut;
          strobeAcc = StbInc;
        end else if (CmdData < CounterOut) begin
          lenAcc    = CounterOut - CmdData;
          strobeAcc = StbDec;
        end
      end
      OpRotlN: begin
        lenAcc    = CmdData;
        strobeAcc = StbR2L;
      end
      default: begin
        lenAcc    = '0;
        strobeAcc = '0;
      end
    endcase
  end

  always_comb begin
    stateD  = stateQ;
    opD     = opQ;
    countD  = countQ;
    dataD   = dataQ;
    strobeD = '0;
    inLsbD  = 1'b0;
    inMsbD  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          opD    = CmdOp;
          countD = lenAcc;
          dataD  = CmdData;
          if (lenAcc == '0) begin
            stateD = StDone;
          end else begin
            stateD  = StRun;
            strobeD = strobeAcc;
            // Serial loads present bit 0 of the sequence now and keep the rest
            // in dataQ, shifted so the next bit is always at the same end.
            if (CmdOp == OpLoadMsb) begin
              inLsbD = CmdData[WIDTH-1];
              dataD  = CmdData << 1;
            end else if (CmdOp == OpLoadLsb) begin
              inMsbD = CmdData[0];
              dataD  = CmdData >> 1;
            end
          end
        end
      end
      StRun: begin
        if (countQ == WIDTH'(1)) begin
          stateD = StDone;
          countD = '0;
        end else begin
          countD  = countQ - WIDTH'(1);
          strobeD = strobeQ;
          if (opQ == OpLoadMsb) begin
            inLsbD = dataQ[WIDTH-1];
            dataD  = dataQ << 1;
          end else if (opQ == OpLoadLsb) begin
            inMsbD = dataQ[0];
            dataD  = dataQ >> 1;
          end
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      stateQ  <= StIdle;
      opQ     <= OpNop;
      countQ  <= '0;
      dataQ   <= '0;
      strobeQ <= '0;
      inLsbQ  <= 1'b0;
      inMsbQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      opQ     <= opD;
      countQ  <= countD;
      dataQ   <= dataD;
      strobeQ <= strobeD;
      inLsbQ  <= inLsbD;
      inMsbQ  <= inMsbD;
    end
  end

  assign DoReset     = strobeQ[4];
  assign DoIncrement = strobeQ[3];
  assign DoDecrement = strobeQ[2];
  assign DoShiftL2R  = strobeQ[1];
  assign DoShiftR2L  = strobeQ[0];

  assign CmdReady = (stateQ == StIdle);
  assign Busy     = (stateQ == StRun);
  assign Done     = (stateQ == StDone);

  assign CounterInMSB = inMsbQ;
  // Rotate feeds the live MSB back in, so it cannot be registered ahead of time.
  assign CounterInLSB = (stateQ == StRun && opQ == OpRotlN) ? CounterOut[WIDTH-1] : inLsbQ;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
module tb_counter_cmd_sequencer;

  localparam logic [2:0] OpNop     = 3'b000;
  localparam logic [2:0] OpClear   = 3'b001;
  localparam logic [2:0] OpIncN    = 3'b010;
  localparam logic [2:0] OpDecN    = 3'b011;
  localparam logic [2:0] OpLoadMsb = 3'b100;
  localparam logic [2:0] OpLoadLsb = 3'b101;
  localparam logic [2:0] OpSeek    = 3'b110;
  localparam logic [2:0] OpRotlN   = 3'b111;

  // {DoReset, DoIncrement, DoDecrement, DoShiftL2R, DoShiftR2L}
  localparam logic [4:0] SNone = 5'b00000;
  localparam logic [4:0] SRst  = 5'b10000;
  localparam logic [4:0] SInc  = 5'b01000;
  localparam logic [4:0] SDec  = 5'b00100;
  localparam logic [4:0] SL2R  = 5'b00010;
  localparam logic [4:0] SR2L  = 5'b00001;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       CmdValid;
  logic       CmdReady;
  logic [2:0] CmdOp;
  logic [7:0] CmdData;
  logic [7:0] CounterOut;
  logic       DoReset, DoIncrement, DoDecrement, DoShiftL2R, DoShiftR2L;
  logic       CounterInMSB, CounterInLSB;
  logic       Busy, Done;

  logic       presetEn = 1'b0;
  logic [7:0] presetVal = 8'h00;
  logic [7:0] cnt = 8'h00;

  int nAssert = 0;
  int nFail = 0;

  logic [4:0] strobes;
  assign strobes = {DoReset, DoIncrement, DoDecrement, DoShiftL2R, DoShiftR2L};
  assign CounterOut = cnt;

  always #5 Clock = ~Clock;

  counter_cmd_sequencer #(.WIDTH(8)) dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .CmdValid    (CmdValid),
    .CmdReady    (CmdReady),
    .CmdOp       (CmdOp),
    .CmdData     (CmdData),
    .CounterOut  (CounterOut),
    .DoReset     (DoReset),
    .DoIncrement (DoIncrement),
    .DoDecrement (DoDecrement),
    .DoShiftL2R  (DoShiftL2R),
    .DoShiftR2L  (DoShiftR2L),
    .CounterInMSB(CounterInMSB),
    .CounterInLSB(CounterInLSB),
    .Busy        (Busy),
    .Done        (Done)
  );

  // Behavioural model of the 8-bit up/down/shift counter being driven.
  always @(posedge Clock) begin
    if (presetEn)          cnt <= presetVal;
    else if (DoReset)      cnt <= 8'h00;
    else if (DoIncrement)  cnt <= cnt + 8'h01;
    else if (DoDecrement)  cnt <= cnt - 8'h01;
    else if (DoShiftR2L)   cnt <= {cnt[6:0], CounterInLSB};
    else if (DoShiftL2R)   cnt <= {CounterInMSB, cnt[7:1]};
  end

  // At most one strobe in any cycle, across every scenario.
  always @(negedge Clock) begin
    nAssert++;
    assert ($countones(strobes) <= 1) else begin
      nFail++;
      $error("FAIL onehot: observed strobes=%b expected at most one set", strobes);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge with the sequencer idle.
  task automatic preset(input logic [7:0] v);
    presetVal = v;
    presetEn  = 1'b1;
    @(negedge Clock);
    presetEn  = 1'b0;
  endtask

  // Issues one command from IDLE and checks the whole strobe sequence.
  task automatic doCmd(input string tag, input logic [2:0] op, input logic [7:0] data,
                       input bit hold, input int expLen, input logic [4:0] expStb,
                       input logic [15:0] expLsb, input logic [15:0] expMsb,
                       input logic [7:0] expFinal);
    int cyc;
    int busyN;
    bit runOk;
    logic [15:0] obsLsb;
    logic [15:0] obsMsb;
    cyc = 0;
    busyN = 0;
    runOk = 1'b1;
    obsLsb = '0;
    obsMsb = '0;
    CmdOp = op;
    CmdData = data;
    CmdValid = 1'b1;
    check({tag, ".ready"}, 32'(CmdReady), 32'd1);
    @(negedge Clock);
    if (!hold) begin
      CmdValid = 1'b0;
      CmdData = ~data;
    end
    while (!Done && cyc < 400) begin
      if (Busy) begin
        if (strobes !== expStb || CmdReady !== 1'b0) runOk = 1'b0;
        if (busyN < 16) begin
          obsLsb[busyN] = CounterInLSB;
          obsMsb[busyN] = CounterInMSB;
        end
        busyN++;
      end else begin
        runOk = 1'b0;
      end
      @(negedge Clock);
      cyc++;
    end
    check({tag, ".done"}, 32'(Done), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(expLen));
    check({tag, ".busycycles"}, 32'(busyN), 32'(expLen));
    check({tag, ".runstrobes"}, 32'(runOk), 32'd1);
    check({tag, ".lsbseq"}, 32'(obsLsb), 32'(expLsb));
    check({tag, ".msbseq"}, 32'(obsMsb), 32'(expMsb));
    check({tag, ".doneoutputs"},
          32'({strobes, CounterInMSB, CounterInLSB, Busy, CmdReady}), 32'd0);
    check({tag, ".counter"}, 32'(CounterOut), 32'(expFinal));
    @(negedge Clock);
    check({tag, ".idle"}, 32'({Done, CmdReady}), 32'b01);
  endtask

  initial begin
    ResetN = 1'b0;
    CmdValid = 1'b0;
    CmdOp = OpNop;
    CmdData = 8'h00;
    #3;
    check("reset.outputs",
          32'({strobes, CounterInMSB, CounterInLSB, Busy, Done}), 32'd0);
    check("reset.ready", 32'(CmdReady), 32'd1);
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);

    // Abandon an INC_N 10 midway with an asynchronous reset.
    preset(8'h00);
    CmdOp = OpIncN;
    CmdData = 8'd10;
    CmdValid = 1'b1;
    @(negedge Clock);
    CmdValid = 1'b0;
    check("midreset.busy", 32'({Busy, DoIncrement}), 32'b11);
    @(negedge Clock);
    @(negedge Clock);
    #2 ResetN = 1'b0;
    #1;
    check("midreset.async",
          32'({strobes, CounterInMSB, CounterInLSB, Busy, Done}), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("midreset.nodone", 32'({Done, Busy, CmdReady}), 32'b001);
    end

    doCmd("clear", OpClear, 8'h77, 1'b0, 1, SRst, 16'h0, 16'h0, 8'h00);

    preset(8'hFE);
    doCmd("inc5wrap", OpIncN, 8'd5, 1'b0, 5, SInc, 16'h0, 16'h0, 8'h03);

    preset(8'h01);
    doCmd("dec2wrap", OpDecN, 8'd2, 1'b0, 2, SDec, 16'h0, 16'h0, 8'hFF);

    // Serial bits per RUN cycle i are collected into bit i of the sequence.
    doCmd("loadmsb", OpLoadMsb, 8'hA5, 1'b0, 8, SR2L, 16'h00A5, 16'h0, 8'hA5);
    doCmd("loadlsb", OpLoadLsb, 8'h3C, 1'b0, 8, SL2R, 16'h0, 16'h003C, 8'h3C);

    preset(8'h10);
    doCmd("seekdown", OpSeek, 8'h0C, 1'b0, 4, SDec, 16'h0, 16'h0, 8'h0C);
    doCmd("seekequal", OpSeek, 8'h0C, 1'b0, 0, SNone, 16'h0, 16'h0, 8'h0C);
    doCmd("seekup", OpSeek, 8'h0F, 1'b0, 3, SInc, 16'h0, 16'h0, 8'h0F);

    // 0x81 -> 0x03 -> 0x06 -> 0x0C, LSB fed with MSB 1,0,0.
    preset(8'h81);
    doCmd("rotl3", OpRotlN, 8'd3, 1'b0, 3, SR2L, 16'h0001, 16'h0, 8'h0C);

    doCmd("nop", OpNop, 8'h55, 1'b0, 0, SNone, 16'h0, 16'h0, 8'h0C);

    // CmdValid held through RUN and DONE: exactly one accept per command.
    preset(8'h00);
    doCmd("holdinc2", OpIncN, 8'd2, 1'b1, 2, SInc, 16'h0, 16'h0, 8'h02);
    doCmd("inczero", OpIncN, 8'd0, 1'b0, 0, SNone, 16'h0, 16'h0, 8'h02);

    @(negedge Clock);
    check("final.idle", 32'({Busy, Done, CmdReady}), 32'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
